vram_write_arbiter: RTL and testbench

- Shares the single VideoRAM write port (vwr/vwaddr/vwdata) between three sources.
  - Port A: serial receive/terminal state machine.
  - Port B: keyboard local-echo / status-line writer.
  - Internal fill engine: bulk clear and scroll-line blanking.
- Fair round-robin grant, one write per clk25 cycle, registered outputs.
- Sits between the writers and the VideoRAM write port, replacing direct wiring from the terminal state machine.

---
 rtl/vram_write_if.sv | 37 +++
 rtl/vram_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_vram_write_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_write_if.sv
// Bundle for the shared VideoRAM write port: requester ports A and B, fill-engine
// control/status, and the arbitrated write port itself.
interface vram_write_if #(
  parameter int AW = 11,
  parameter int DW = 8,
  parameter int LW = 12
);
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ack;
  logic          b_req;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ack;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [LW-1:0] fill_len;
  logic [DW-1:0] fill_char;
  logic          fill_busy;
  logic          fill_done;
  logic          vwr;
  logic [AW-1:0] vwaddr;
  logic [DW-1:0] vwdata;

  modport master (
    output a_req, a_addr, a_data, b_req, b_addr, b_data,
           fill_start, fill_base, fill_len, fill_char,
    input  a_ack, b_ack, fill_busy, fill_done, vwr, vwaddr, vwdata
  );

  modport slave (
    input  a_req, a_addr, a_data, b_req, b_addr, b_data,
           fill_start, fill_base, fill_len, fill_char,
    output a_ack, b_ack, fill_busy, fill_done, vwr, vwaddr, vwdata
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter for the single VideoRAM write port: ports A and B plus an
// internal fill engine, one registered write per clk25 cycle.
module vram_write_arbiter #(
  parameter int AW = 11,
  parameter int DW = 8,
  parameter int LW = 12
) (
  input  logic        clk25,
  input  logic        rst,
  vram_write_if.slave bus
);
  typedef enum logic [1:0] {SRC_A = 2'd0, SRC_B = 2'd1, SRC_FILL = 2'd2} src_e;
  typedef enum logic {F_IDLE = 1'b0, F_RUN = 1'b1} fill_state_e;

  localparam logic [LW-1:0] MAX_LEN = LW'(2 ** AW);

  function automatic src_e src_after(input src_e s);
    case (s)
      SRC_A:    src_after = SRC_B;
      SRC_B:    src_after = SRC_FILL;
      SRC_FILL: src_after = SRC_A;
      default:  src_after = SRC_A;
    endcase
  endfunction

  src_e          last_r, last_s, cand1_s, cand2_s, grant_s;
  fill_state_e   fill_state_r, fill_state_s;
  logic          grant_vld_s;
  logic [2:0]    elig_s;
  logic [AW-1:0] fill_addr_r, fill_addr_s;
  logic [LW-1:0] fill_cnt_r, fill_cnt_s, start_len_s;
  logic [DW-1:0] fill_char_r, fill_char_s;
  logic          vwr_r, vwr_s;
  logic [AW-1:0] vwaddr_r, vwaddr_s;
  logic [DW-1:0] vwdata_r, vwdata_s;
  logic          a_ack_r, a_ack_s, b_ack_r, b_ack_s, fill_done_r, fill_done_s;

  // Grant selection: first eligible source in rotating order after the last winner.
  always_comb begin
    elig_s      = {fill_state_r == F_RUN, bus.b_req, bus.a_req};
    cand1_s     = src_after(last_r);
    cand2_s     = src_after(cand1_s);
    grant_vld_s = 1'b1;
    grant_s     = last_r;
    if (elig_s[cand1_s]) begin
      grant_s = cand1_s;
    end else if (elig_s[cand2_s]) begin
      grant_s = cand2_s;
    end else if (elig_s[last_r]) begin
      grant_s = last_r;
    end else begin
      grant_vld_s = 1'b0;
    end
  end

  // Next-state for the write port, acks and fill engine.
  always_comb begin
    last_s       = last_r;
    fill_state_s = fill_state_r;
    fill_addr_s  = fill_addr_r;
    fill_cnt_s   = fill_cnt_r;
    fill_char_s  = fill_char_r;
    vwr_s        = grant_vld_s;
    vwaddr_s     = vwaddr_r;
    vwdata_s     = vwdata_r;
    a_ack_s      = 1'b0;
    b_ack_s      = 1'b0;
    fill_done_s  = 1'b0;
    start_len_s  = (bus.fill_len > MAX_LEN) ? MAX_LEN : bus.fill_len;

    if (grant_vld_s) begin
      last_s = grant_s;
      case (grant_s)
        SRC_A: begin
          vwaddr_s = bus.a_addr;
          vwdata_s = bus.a_data;
          a_ack_s  = 1'b1;
        end
        SRC_B: begin
          vwaddr_s = bus.b_addr;
          vwdata_s = bus.b_data;
          b_ack_s  = 1'b1;
        end
        SRC_FILL: begin
          vwaddr_s    = fill_addr_r;
          vwdata_s    = fill_char_r;
          fill_addr_s = fill_addr_r + AW'(1);
          fill_cnt_s  = fill_cnt_r - LW'(1);
          // The final fill write and the busy->done transition share one cycle.
          if (fill_cnt_r == LW'(1)) begin
            fill_state_s = F_IDLE;
            fill_done_s  = 1'b1;
          end else begin
            fill_state_s = F_RUN;
          end
        end
        default: begin
          vwr_s = 1'b0;
        end
      endcase
    end else begin
      last_s = last_r;
    end

    // A start while a fill is running is ignored; a zero-length fill completes at once.
    if (fill_state_r == F_IDLE && bus.fill_start) begin
      fill_addr_s = bus.fill_base;
      fill_char_s = bus.fill_char;
      fill_cnt_s  = start_len_s;
      if (start_len_s == LW'(0)) begin
        fill_done_s = 1'b1;
      end else begin
        fill_state_s = F_RUN;
      end
    end else begin
      fill_char_s = fill_char_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      last_r       <= SRC_FILL;
      fill_state_r <= F_IDLE;
      fill_addr_r  <= '0;
      fill_cnt_r   <= '0;
      fill_char_r  <= '0;
      vwr_r        <= 1'b0;
      vwaddr_r     <= '0;
      vwdata_r     <= '0;
      a_ack_r      <= 1'b0;
      b_ack_r      <= 1'b0;
      fill_done_r  <= 1'b0;
    end else begin
      last_r       <= last_s;
      fill_state_r <= fill_state_s;
      fill_addr_r  <= fill_addr_s;
      fill_cnt_r   <= fill_cnt_s;
      fill_char_r  <= fill_char_s;
      vwr_r        <= vwr_s;
      vwaddr_r     <= vwaddr_s;
      vwdata_r     <= vwdata_s;
      a_ack_r      <= a_ack_s;
      b_ack_r      <= b_ack_s;
      fill_done_r  <= fill_done_s;
    end
  end

  assign bus.vwr       = vwr_r;
  assign bus.vwaddr    = vwaddr_r;
  assign bus.vwdata    = vwdata_r;
  assign bus.a_ack     = a_ack_r;
  assign bus.b_ack     = b_ack_r;
  assign bus.fill_done = fill_done_r;
  assign bus.fill_busy = (fill_state_r == F_RUN);
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: a behavioural round-robin/fill model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_vram_write_arbiter;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int LW    = 12;
  localparam int NCELL = 2048;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;

  vram_write_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();
  vram_write_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (.clk25(clk25), .rst(rst), .bus(bus));

  always #20 clk25 = ~clk25;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sources numbered 0=A, 1=B, 2=FILL; last winner starts at FILL.
  int   m_last = 2;
  bit   m_fill_on = 1'b0;
  int   m_faddr = 0, m_frem = 0, m_fchar = 0, m_g = -1;
  bit   m_was_on = 1'b0;
  logic e_vwr = 1'b0, e_aack = 1'b0, e_back = 1'b0, e_done = 1'b0;
  int   e_addr = 0, e_data = 0;

  function automatic bit eligible(input int s);
    if (s == 0) return bus.a_req;
    if (s == 1) return bus.b_req;
    return m_fill_on;
  endfunction

  initial forever begin
    @(posedge clk25 or posedge rst);
    if (rst) begin
      m_last = 2; m_fill_on = 1'b0; m_faddr = 0; m_frem = 0; m_fchar = 0;
      e_vwr = 1'b0; e_aack = 1'b0; e_back = 1'b0; e_done = 1'b0; e_addr = 0; e_data = 0;
    end else begin
      m_g = -1;
      m_was_on = m_fill_on;
      for (int k = 1; k <= 3; k++)
        if (m_g < 0 && eligible((m_last + k) % 3)) m_g = (m_last + k) % 3;
      e_vwr  = (m_g >= 0);
      e_aack = (m_g == 0);
      e_back = (m_g == 1);
      e_done = 1'b0;
      if (m_g == 0) begin e_addr = int'(bus.a_addr); e_data = int'(bus.a_data); end
      if (m_g == 1) begin e_addr = int'(bus.b_addr); e_data = int'(bus.b_data); end
      if (m_g == 2) begin
        e_addr  = m_faddr;
        e_data  = m_fchar;
        m_faddr = (m_faddr + 1) % NCELL;
        m_frem  = m_frem - 1;
        if (m_frem == 0) begin m_fill_on = 1'b0; e_done = 1'b1; end
      end
      if (m_g >= 0) m_last = m_g;
      if (bus.fill_start && !m_was_on) begin
        m_faddr = int'(bus.fill_base);
        m_fchar = int'(bus.fill_char);
        m_frem  = (int'(bus.fill_len) > NCELL) ? NCELL : int'(bus.fill_len);
        if (m_frem == 0) e_done = 1'b1;
        else m_fill_on = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk25);
    if (chk_en) begin
      check("vwr", bus.vwr, e_vwr);
      check("vwaddr", bus.vwaddr, e_addr);
      check("vwdata", bus.vwdata, e_data);
      check("a_ack", bus.a_ack, e_aack);
      check("b_ack", bus.b_ack, e_back);
      check("fill_busy", bus.fill_busy, m_fill_on);
      check("fill_done", bus.fill_done, e_done);
    end
  end

  task automatic clear_inputs();
    bus.a_req = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_req = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.fill_start = 1'b0; bus.fill_base = '0; bus.fill_len = '0; bus.fill_char = '0;
  endtask

  task automatic do_reset();
    #5 rst = 1'b1;
    clear_inputs();
    @(negedge clk25);
    @(negedge clk25);
    rst = 1'b0;
  endtask

  task automatic start_fill(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic [DW-1:0] ch);
    bus.fill_start = 1'b1; bus.fill_base = base; bus.fill_len = len; bus.fill_char = ch;
    @(negedge clk25);
    bus.fill_start = 1'b0;
  endtask

  initial begin
    int wr, dones, src, last_addr;
    clear_inputs();
    repeat (2) @(negedge clk25);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_vwr", bus.vwr, 32'd0);
    check("rst_vwaddr", bus.vwaddr, 32'd0);
    check("rst_acks", {bus.a_ack, bus.b_ack}, 32'd0);
    check("rst_busy", bus.fill_busy, 32'd0);

    // Single A write, one-cycle latency.
    bus.a_req = 1'b1; bus.a_addr = 11'd5; bus.a_data = 8'h41;
    @(negedge clk25);
    check("t1_vwr", bus.vwr, 32'd1);
    check("t1_addr", bus.vwaddr, 32'd5);
    check("t1_data", bus.vwdata, 32'h41);
    check("t1_ack", bus.a_ack, 32'd1);
    bus.a_req = 1'b0;
    @(negedge clk25);
    check("t1_vwr_after", bus.vwr, 32'd0);
    check("t1_ack_after", bus.a_ack, 32'd0);
    check("t1_addr_hold", bus.vwaddr, 32'd5);

    // A and B held together from reset alternate A,B,A,B,...
    do_reset();
    bus.a_req = 1'b1; bus.a_addr = 11'd10; bus.a_data = 8'h01;
    bus.b_req = 1'b1; bus.b_addr = 11'd20; bus.b_data = 8'h02;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk25);
      check("t2_aack", bus.a_ack, (i % 2 == 0));
      check("t2_back", bus.b_ack, (i % 2 == 1));
      check("t2_addr", bus.vwaddr, (i % 2 == 0) ? 32'd10 : 32'd20);
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;

    // Wrapping fill of 16 cells from 2040.
    start_fill(11'd2040, 12'd16, 8'h20);
    wr = 0;
    for (int c = 0; c < 40 && wr < 16; c++) begin
      @(negedge clk25);
      if (bus.vwr) begin
        check("t3_addr", bus.vwaddr, (2040 + wr) % 2048);
        check("t3_data", bus.vwdata, 32'h20);
        check("t3_done", bus.fill_done, (wr == 15));
        wr++;
      end
    end
    check("t3_count", wr, 32'd16);
    @(negedge clk25);
    check("t3_busy_end", bus.fill_busy, 32'd0);

    // Fill of 10 competing with A and B held high: strict A,B,FILL rotation.
    do_reset();
    bus.a_req = 1'b1; bus.a_addr = 11'd30; bus.b_req = 1'b1; bus.b_addr = 11'd40;
    bus.fill_start = 1'b1; bus.fill_base = 11'd300; bus.fill_len = 12'd10; bus.fill_char = 8'h2e;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk25);
      bus.fill_start = 1'b0;
      src = bus.a_ack ? 0 : (bus.b_ack ? 1 : (bus.vwr ? 2 : 3));
      check("t4_src", src, c % 3);
      check("t4_done", bus.fill_done, (c == 29));
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(negedge clk25);
    check("t4_busy_end", bus.fill_busy, 32'd0);

    // Zero-length fill.
    start_fill(11'd50, 12'd0, 8'h20);
    check("t5_done", bus.fill_done, 32'd1);
    check("t5_busy", bus.fill_busy, 32'd0);
    check("t5_vwr", bus.vwr, 32'd0);
    @(negedge clk25);
    check("t5_done_clear", bus.fill_done, 32'd0);

    // Second start during a running fill is ignored.
    start_fill(11'd100, 12'd8, 8'h41);
    wr = 0; dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk25);
      bus.fill_start = 1'b0;
      if (c == 3) begin
        bus.fill_start = 1'b1; bus.fill_base = 11'd500; bus.fill_len = 12'd5;
      end
      if (bus.vwr) begin check("t5b_addr", bus.vwaddr, 100 + wr); wr++; end
      if (bus.fill_done) dones++;
    end
    check("t5b_count", wr, 32'd8);
    check("t5b_dones", dones, 32'd1);

    // Oversized length saturates to the whole VideoRAM.
    start_fill(11'd7, 12'd3000, 8'h55);
    wr = 0; dones = 0; last_addr = -1;
    for (int c = 0; c < 2200; c++) begin
      @(negedge clk25);
      if (bus.vwr) begin wr++; last_addr = int'(bus.vwaddr); end
      if (bus.fill_done) dones++;
    end
    check("sat_count", wr, 32'd2048);
    check("sat_last_addr", last_addr, 32'd6);
    check("sat_dones", dones, 32'd1);

    // Reset in the middle of a 100-cell fill.
    start_fill(11'd0, 12'd100, 8'h20);
    wr = 0;
    for (int c = 0; c < 80 && wr < 40; c++) begin
      @(negedge clk25);
      if (bus.vwr) wr++;
    end
    check("t6_pre_writes", wr, 32'd40);
    #5 rst = 1'b1;
    #1;
    check("t6_vwr_async", bus.vwr, 32'd0);
    check("t6_busy_async", bus.fill_busy, 32'd0);
    check("t6_done_async", bus.fill_done, 32'd0);
    @(negedge clk25);
    @(negedge clk25);
    rst = 1'b0;
    bus.a_req = 1'b1; bus.a_addr = 11'd77; bus.a_data = 8'h09;
    @(negedge clk25);
    check("t6_aack", bus.a_ack, 32'd1);
    check("t6_addr", bus.vwaddr, 32'd77);
    check("t6_no_done", bus.fill_done, 32'd0);
    bus.a_req = 1'b0;
    @(negedge clk25);

    // Random traffic; the every-cycle comparison does the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!bus.a_req || bus.a_ack) begin
        if ($urandom_range(99) < 60) begin
          bus.a_req = 1'b1; bus.a_addr = AW'($urandom); bus.a_data = DW'($urandom);
        end else begin
          bus.a_req = 1'b0;
        end
      end
      if (!bus.b_req || bus.b_ack) begin
        if ($urandom_range(99) < 45) begin
          bus.b_req = 1'b1; bus.b_addr = AW'($urandom); bus.b_data = DW'($urandom);
        end else begin
          bus.b_req = 1'b0;
        end
      end
      bus.fill_start = 1'b0;
      if ($urandom_range(39) == 0) begin
        bus.fill_start = 1'b1;
        bus.fill_base  = AW'($urandom);
        bus.fill_len   = LW'($urandom_range(0, 24));
        bus.fill_char  = DW'($urandom);
      end
      @(negedge clk25);
    end
    clear_inputs();
    repeat (3) @(negedge clk25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
